// File: rtl/ov7670_pkg.sv
// Shared constants, FSM state type and SCCB frame builder for the OV7670 init sequencer.
package ov7670_pkg;

   localparam logic [7:0]  SCCB_ID_W  = 8'h42;
   localparam logic [15:0] ROM_END    = 16'hFFFF;
   localparam logic [7:0]  COM7_ADDR  = 8'h12;
   localparam logic [7:0]  COM7_SWRST = 8'h80;
   localparam int          FRAME_BITS = 27;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      BITS,
      STOP,
      GAP,
      RSTWAIT,
      DONE
   } state_t;

   // Three bytes MSB-first, each followed by a released (1) don't-care/ACK slot.
   function automatic logic [FRAME_BITS-1:0] sccb_frame(input logic [15:0] entry);
      return {SCCB_ID_W, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
   endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// {reg,val} init table with registered read. TABLE_SEL picks the production list (0)
// or small fixed lists: 1 = two entries, 2 = empty, 3 = no terminator.
module ov7670_reg_rom
   import ov7670_pkg::*;
#(
   parameter int ROM_AW    = 8,
   parameter int TABLE_SEL = 0
) (
   input  logic              clk,
   input  logic [ROM_AW-1:0] addr,
   output logic [15:0]       data
);

   localparam int DEPTH = 1 << ROM_AW;

   function automatic logic [15:0] table_entry(input int idx);
      logic [15:0] e;
      e = ROM_END;
      case (TABLE_SEL)
         1: begin
            case (idx)
               0:       e = 16'h1280;
               1:       e = 16'h1101;
               default: e = ROM_END;
            endcase
         end
         2: e = ROM_END;
         3: e = {8'h20, 8'(idx)};
         default: begin
            // RGB565 output, default clocking, colour matrix and window setup
            case (idx)
               0:       e = 16'h1204;
               1:       e = 16'h1100;
               2:       e = 16'h0C00;
               3:       e = 16'h3E00;
               4:       e = 16'h8C00;
               5:       e = 16'h0400;
               6:       e = 16'h40D0;
               7:       e = 16'h3A04;
               8:       e = 16'h1438;
               9:       e = 16'h4FB3;
               10:      e = 16'h50B3;
               11:      e = 16'h5100;
               12:      e = 16'h523D;
               13:      e = 16'h53A7;
               14:      e = 16'h54E4;
               15:      e = 16'h589E;
               16:      e = 16'h3DC0;
               17:      e = 16'h1711;
               18:      e = 16'h1861;
               19:      e = 16'h32A4;
               20:      e = 16'h1903;
               21:      e = 16'h1A7B;
               22:      e = 16'h030A;
               default: e = ROM_END;
            endcase
         end
      endcase
      return e;
   endfunction

   logic [15:0] rom_mem [DEPTH];
   logic [15:0] data_reg;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
      assign rom_mem[gi] = table_entry(gi);
   end

   always_ff @(posedge clk) begin
      data_reg <= rom_mem[addr];
   end

   assign data = data_reg;

endmodule

// File: rtl/ov7670_sccb_init.sv
// OV7670 register-init sequencer: writes the ROM list over SCCB (ID, reg, val) after a
// start rising edge. Optional OV7670_SWRST_EN prefixes a COM7 soft reset plus 1 ms wait.
// GAP_CYCLES must be >= 2 (the LOAD cycle counts as one of the idle cycles).
module ov7670_sccb_init
   import ov7670_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int SCCB_HZ    = 100_000,
   parameter int GAP_CYCLES = 500,
   parameter int ROM_AW     = 8,
   parameter int TABLE_SEL  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              sioc,
   output logic              siod_oe,
   output logic              busy,
   output logic              done,
   output logic [ROM_AW-1:0] reg_idx
);

   localparam int Q_RAW = CLK_HZ / (4 * SCCB_HZ);
   localparam int Q     = (Q_RAW < 1) ? 1 : Q_RAW;
   localparam int QW    = (Q > 1) ? $clog2(Q) : 1;
`ifdef OV7670_SWRST_EN
   localparam int SWRST_CYCLES = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
   localparam int WAIT_MAX     = (SWRST_CYCLES > GAP_CYCLES) ? SWRST_CYCLES : GAP_CYCLES;
`else
   localparam int WAIT_MAX     = GAP_CYCLES;
`endif
   localparam int WW = $clog2(WAIT_MAX + 1);

   state_t                state_reg, state_next;
   logic [QW-1:0]         q_cnt_reg, q_cnt_next;
   logic [1:0]            qph_reg, qph_next;
   logic [4:0]            bit_cnt_reg, bit_cnt_next;
   logic [FRAME_BITS-1:0] shift_reg, shift_next;
   logic [WW-1:0]         wait_reg, wait_next;
   logic [ROM_AW-1:0]     reg_idx_reg, reg_idx_next;
   logic                  sioc_reg, sioc_next;
   logic                  siod_oe_reg, siod_oe_next;
   logic                  start_d_reg;
   logic                  start_rise;
   logic                  q_tick;
   logic [15:0]           rom_data;
   logic [15:0]           entry;
`ifdef OV7670_SWRST_EN
   logic                  swrst_pend_reg, swrst_pend_next;
`endif

   // Addressed with the next index so the registered data matches reg_idx_reg in LOAD.
   ov7670_reg_rom #(
      .ROM_AW    (ROM_AW),
      .TABLE_SEL (TABLE_SEL)
   ) u_rom (
      .clk  (clk),
      .addr (reg_idx_next),
      .data (rom_data)
   );

`ifdef OV7670_SWRST_EN
   assign entry = swrst_pend_reg ? {COM7_ADDR, COM7_SWRST} : rom_data;
`else
   assign entry = rom_data;
`endif

   assign start_rise = start & ~start_d_reg;
   assign q_tick     = (q_cnt_reg == QW'(Q - 1));

   always_comb begin
      state_next   = state_reg;
      q_cnt_next   = '0;
      qph_next     = qph_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      wait_next    = wait_reg;
      reg_idx_next = reg_idx_reg;
      sioc_next    = 1'b1;
      siod_oe_next = 1'b0;
`ifdef OV7670_SWRST_EN
      swrst_pend_next = swrst_pend_reg;
`endif
      if (state_reg inside {START, BITS, STOP}) begin
         q_cnt_next = q_tick ? '0 : q_cnt_reg + 1'b1;
      end
      unique case (state_reg)
         IDLE: begin
            if (start_rise) begin
               state_next = LOAD;
`ifdef OV7670_SWRST_EN
               swrst_pend_next = 1'b1;
`endif
            end
         end
         LOAD: begin
            if (entry == ROM_END) begin
               state_next = DONE;
            end else begin
               shift_next = sccb_frame(entry);
               qph_next   = '0;
               state_next = START;
            end
         end
         START: begin
            siod_oe_next = 1'b1;
            if (q_tick) begin
               qph_next = qph_reg + 1'b1;
               if (qph_reg == 2'd1) begin
                  qph_next     = '0;
                  bit_cnt_next = '0;
                  state_next   = BITS;
               end
            end
         end
         BITS: begin
            sioc_next    = (qph_reg == 2'd1) || (qph_reg == 2'd2);
            siod_oe_next = ~shift_reg[FRAME_BITS-1];
            if (q_tick) begin
               qph_next = qph_reg + 1'b1;
               if (qph_reg == 2'd3) begin
                  shift_next   = shift_reg << 1;
                  bit_cnt_next = bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == 5'(FRAME_BITS - 1)) begin
                     state_next = STOP;
                  end
               end
            end
         end
         STOP: begin
            siod_oe_next = (qph_reg == 2'd0);
            if (q_tick) begin
               qph_next = qph_reg + 1'b1;
               if (qph_reg == 2'd1) begin
                  qph_next   = '0;
                  wait_next  = '0;
                  state_next = GAP;
`ifdef OV7670_SWRST_EN
                  if (swrst_pend_reg) begin
                     state_next      = RSTWAIT;
                     swrst_pend_next = 1'b0;
                  end
`endif
               end
            end
         end
         GAP: begin
            if (wait_reg == WW'(GAP_CYCLES - 2)) begin
               // A full list without terminator stops here instead of wrapping.
               if (reg_idx_reg == '1) begin
                  state_next = DONE;
               end else begin
                  reg_idx_next = reg_idx_reg + 1'b1;
                  state_next   = LOAD;
               end
            end else begin
               wait_next = wait_reg + 1'b1;
            end
         end
`ifdef OV7670_SWRST_EN
         RSTWAIT: begin
            if (wait_reg == WW'(SWRST_CYCLES - 1)) begin
               state_next = LOAD;
            end else begin
               wait_next = wait_reg + 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      start_d_reg <= start;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         q_cnt_reg   <= '0;
         qph_reg     <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         wait_reg    <= '0;
         reg_idx_reg <= '0;
         sioc_reg    <= 1'b1;
         siod_oe_reg <= 1'b0;
`ifdef OV7670_SWRST_EN
         swrst_pend_reg <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         q_cnt_reg   <= q_cnt_next;
         qph_reg     <= qph_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
         wait_reg    <= wait_next;
         reg_idx_reg <= reg_idx_next;
         sioc_reg    <= sioc_next;
         siod_oe_reg <= siod_oe_next;
`ifdef OV7670_SWRST_EN
         swrst_pend_reg <= swrst_pend_next;
`endif
      end
   end

   assign sioc    = sioc_reg;
   assign siod_oe = siod_oe_reg;
   assign busy    = (state_reg != IDLE) && (state_reg != DONE);
   assign done    = (state_reg == DONE);
   assign reg_idx = reg_idx_reg;

endmodule
